// File: rtl/mult_seq_ctrl.sv
// Multi-cycle WIDTH x WIDTH unsigned multiplier sequenced through one 2x2 array-multiplier tile.
// Optional macro MULT_SKIP_ZERO_EN collapses rows whose multiplicand digit is zero to a single cycle.
module mult_seq_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int D  = WIDTH / 2;
  localparam int IW = (D > 1) ? $clog2(D) : 1;
  localparam int PW = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_next;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic [IW-1:0]    i, j;
  logic [PW-1:0]    acc, acc_next, p_ext;
  logic [1:0]       da, db;
  logic [3:0]       p;
  logic [IW:0]      dsum;
  logic             skip_row, row_end, last;
  logic             pp00, pp10, pp01, pp11, c1;

  assign da = a_reg[2*i +: 2];
  assign db = b_reg[2*j +: 2];

  // 2x2 array multiplier: AND-plane partial products reduced by two half adders
  assign pp00 = da[0] & db[0];
  assign pp10 = da[1] & db[0];
  assign pp01 = da[0] & db[1];
  assign pp11 = da[1] & db[1];
  assign c1   = pp10 & pp01;
  assign p    = {pp11 & c1, pp11 ^ c1, pp10 ^ pp01, pp00};

`ifdef MULT_SKIP_ZERO_EN
  assign skip_row = (j == '0) && (da == 2'b00);
`else
  assign skip_row = 1'b0;
`endif

  assign row_end  = skip_row || (j == IW'(D - 1));
  assign last     = row_end && (i == IW'(D - 1));
  assign dsum     = {1'b0, i} + {1'b0, j};
  assign p_ext    = {{(PW-4){1'b0}}, p};
  assign acc_next = skip_row ? acc : acc + (p_ext << {dsum, 1'b0});

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Digit indices walk j fastest; product only updates on the final digit pair
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg   <= '0;
      b_reg   <= '0;
      i       <= '0;
      j       <= '0;
      acc     <= '0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= b;
            acc   <= '0;
            i     <= '0;
            j     <= '0;
          end
        end
        CALC: begin
          acc <= acc_next;
          if (row_end) begin
            j <= '0;
            i <= i + 1'b1;
          end else begin
            j <= j + 1'b1;
          end
          if (last) product <= acc_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Self-checking bench for mult_seq_ctrl: directed cases plus random operands against an arithmetic model.
// Expected CALC length follows MULT_SKIP_ZERO_EN when that macro is defined for the build.
module tb_mult_seq_ctrl;

  localparam int WIDTH = 8;
  localparam int D     = WIDTH / 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] product;
  logic        busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mult_seq_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int expLatency(input logic [7:0] opa);
    int n;
    n = 0;
`ifdef MULT_SKIP_ZERO_EN
    for (int r = 0; r < D; r++) n += (opa[2*r +: 2] != 2'b00) ? D : 1;
`else
    n = D * D;
`endif
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; hold = cycles out_valid sits unacknowledged, noise = garble inputs during CALC
  task automatic applyStimulus(input logic [7:0] opa, input logic [7:0] opb,
                               input int hold, input bit noise);
    int          cyc;
    int          lat;
    logic [15:0] exp;
    exp = {8'b0, opa} * {8'b0, opb};
    lat = expLatency(opa);
    cyc = 0;
    while (!in_ready && cyc < 10) begin
      tick();
      cyc++;
    end
    checkOutput("in_ready_idle", in_ready, 1);
    a         = opa;
    b         = opb;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    tick();
    in_valid = 1'b0;
    checkOutput("busy_calc", busy, 1);
    checkOutput("in_ready_calc", in_ready, 0);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      if (noise) begin
        a        = 8'($urandom);
        b        = 8'($urandom);
        in_valid = 1'($urandom_range(0, 1));
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    checkOutput("latency", cyc, lat);
    checkOutput("product", product, exp);
    checkOutput("in_ready_done", in_ready, 0);
    checkOutput("busy_done", busy, 1);
    for (int k = 1; k < hold; k++) begin
      tick();
      checkOutput("hold_valid", out_valid, 1);
      checkOutput("hold_product", product, exp);
      checkOutput("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    checkOutput("valid_drop", out_valid, 0);
    checkOutput("in_ready_after", in_ready, 1);
    checkOutput("busy_after", busy, 0);
    checkOutput("product_kept", product, exp);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] ra, rb;
    rst       = 1'b1;
    in_valid  = 1'b1;
    a         = 8'hFF;
    b         = 8'hFF;
    out_ready = 1'b0;
    tick();
    tick();
    in_valid = 1'b0;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_product", product, 0);
    checkOutput("rst_busy", busy, 0);
    rst = 1'b0;
    tick();
    checkOutput("post_rst_in_ready", in_ready, 1);
    checkOutput("post_rst_busy", busy, 0);

    applyStimulus(8'hFF, 8'hFF, 0, 1'b0);
    applyStimulus(8'd13, 8'd11, 0, 1'b0);
    applyStimulus(8'h00, 8'hAB, 0, 1'b0);
    applyStimulus(8'd200, 8'd3, 5, 1'b0);
    applyStimulus(8'h5A, 8'h33, 0, 1'b1);
    applyStimulus(8'h03, 8'hFF, 0, 1'b0);
    applyStimulus(8'h00, 8'hFF, 0, 1'b0);

    $display("[TB] reset during CALC");
    a        = 8'hFF;
    b        = 8'hFF;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    rst      = 1'b1;
    in_valid = 1'b1;
    tick();
    checkOutput("abort_out_valid", out_valid, 0);
    checkOutput("abort_product", product, 0);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_in_ready", in_ready, 1);
    rst      = 1'b0;
    in_valid = 1'b0;
    repeat (20) tick();
    checkOutput("abort_no_result", out_valid, 0);
    applyStimulus(8'd2, 8'd3, 0, 1'b0);

    $display("[TB] random operands");
    for (int n = 0; n < 12; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      for (int r = 0; r < D; r++)
        if ($urandom_range(0, 2) == 0) ra[2*r +: 2] = 2'b00;
      applyStimulus(ra, rb, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
